// File: rtl/axis_swap_arbiter.sv
// axis_swap_arbiter
//   Packet-level round-robin arbiter that shares one downstream byte-swap
//   datapath between two AXI Stream sources. A source owns the output for a
//   whole packet (through TLAST). The swap enable for the packet is taken from
//   swap_cfg at grant time and held until the next grant.
//
// Ports
//   clk, rst          clock; asynchronous active-low reset
//   swap_cfg[1:0]     per-source swap enable, sampled at grant
//   s0_*, s1_*        AXI Stream slave inputs (TDATA/TKEEP/TLAST/TVALID/TREADY)
//   out_*             AXI Stream master output toward the swap block
//   enable_swap       swap enable for the packet in flight
//   grant[1:0]        one-hot owner (01 = source 0, 10 = source 1, 00 = idle)
//   pkt_count0/1      completed packets per source, wrapping
module axis_swap_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              swap_cfg,
    input  logic [DATA_WIDTH-1:0]   s0_TDATA,
    input  logic [DATA_WIDTH/8-1:0] s0_TKEEP,
    input  logic                    s0_TLAST,
    input  logic                    s0_TVALID,
    output logic                    s0_TREADY,
    input  logic [DATA_WIDTH-1:0]   s1_TDATA,
    input  logic [DATA_WIDTH/8-1:0] s1_TKEEP,
    input  logic                    s1_TLAST,
    input  logic                    s1_TVALID,
    output logic                    s1_TREADY,
    output logic [DATA_WIDTH-1:0]   out_TDATA,
    output logic [DATA_WIDTH/8-1:0] out_TKEEP,
    output logic                    out_TLAST,
    output logic                    out_TVALID,
    input  logic                    out_TREADY,
    output logic                    enable_swap,
    output logic [1:0]              grant,
    output logic [CNT_WIDTH-1:0]    pkt_count0,
    output logic [CNT_WIDTH-1:0]    pkt_count1
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t state;
    logic   last;   // most recently granted source (1 = source 1)

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            last        <= 1'b1;
            enable_swap <= 1'b0;
            grant       <= 2'b00;
            pkt_count0  <= '0;
            pkt_count1  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // Source 0 wins when it is the only requester, or when
                    // both request and source 1 had the previous grant.
                    if (s0_TVALID && (!s1_TVALID || last)) begin
                        state       <= GNT0;
                        grant       <= 2'b01;
                        last        <= 1'b0;
                        enable_swap <= swap_cfg[0];
                    end else if (s1_TVALID) begin
                        state       <= GNT1;
                        grant       <= 2'b10;
                        last        <= 1'b1;
                        enable_swap <= swap_cfg[1];
                    end
                end
                GNT0: begin
                    if (s0_TVALID && out_TREADY && s0_TLAST) begin
                        state      <= IDLE;
                        grant      <= 2'b00;
                        pkt_count0 <= pkt_count0 + 1'b1;
                    end
                end
                GNT1: begin
                    if (s1_TVALID && out_TREADY && s1_TLAST) begin
                        state      <= IDLE;
                        grant      <= 2'b00;
                        pkt_count1 <= pkt_count1 + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= 2'b00;
                end
            endcase
        end
    end

    // Zero-latency pass-through of the owning source; everything idles at 0.
    always_comb begin
        out_TDATA  = '0;
        out_TKEEP  = '0;
        out_TLAST  = 1'b0;
        out_TVALID = 1'b0;
        s0_TREADY  = 1'b0;
        s1_TREADY  = 1'b0;
        case (state)
            GNT0: begin
                out_TDATA  = s0_TDATA;
                out_TKEEP  = s0_TKEEP;
                out_TLAST  = s0_TLAST;
                out_TVALID = s0_TVALID;
                s0_TREADY  = out_TREADY;
            end
            GNT1: begin
                out_TDATA  = s1_TDATA;
                out_TKEEP  = s1_TKEEP;
                out_TLAST  = s1_TLAST;
                out_TVALID = s1_TVALID;
                s1_TREADY  = out_TREADY;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_axis_swap_arbiter.sv
// Bench for axis_swap_arbiter. The counter width is reduced so that
// counter wrap-around is reachable in a short run.
module tb_axis_swap_arbiter;
    localparam int DW = 32;
    localparam int KW = DW / 8;
    localparam int CW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [1:0]    swap_cfg;
    logic [DW-1:0] s0_TDATA, s1_TDATA, out_TDATA;
    logic [KW-1:0] s0_TKEEP, s1_TKEEP, out_TKEEP;
    logic          s0_TLAST, s0_TVALID, s0_TREADY;
    logic          s1_TLAST, s1_TVALID, s1_TREADY;
    logic          out_TLAST, out_TVALID, out_TREADY;
    logic          enable_swap;
    logic [1:0]    grant;
    logic [CW-1:0] pkt_count0, pkt_count1;

    axis_swap_arbiter #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .swap_cfg(swap_cfg),
        .s0_TDATA(s0_TDATA), .s0_TKEEP(s0_TKEEP), .s0_TLAST(s0_TLAST),
        .s0_TVALID(s0_TVALID), .s0_TREADY(s0_TREADY),
        .s1_TDATA(s1_TDATA), .s1_TKEEP(s1_TKEEP), .s1_TLAST(s1_TLAST),
        .s1_TVALID(s1_TVALID), .s1_TREADY(s1_TREADY),
        .out_TDATA(out_TDATA), .out_TKEEP(out_TKEEP), .out_TLAST(out_TLAST),
        .out_TVALID(out_TVALID), .out_TREADY(out_TREADY),
        .enable_swap(enable_swap), .grant(grant),
        .pkt_count0(pkt_count0), .pkt_count1(pkt_count1)
    );

    typedef struct packed {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
    } beat_t;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
        logic          en;
        logic [1:0]    g;
    } exp_t;

    beat_t q0[$];
    beat_t q1[$];
    exp_t  exp_q[$];
    logic  src_en0, src_en1;
    int    tests = 0;
    int    fails = 0;

    // Present the head of each source queue on its interface.
    task automatic drive_srcs();
        beat_t b0, b1;
        b0 = (q0.size() > 0) ? q0[0] : '0;
        b1 = (q1.size() > 0) ? q1[0] : '0;
        {s0_TDATA, s0_TKEEP, s0_TLAST} = b0;
        {s1_TDATA, s1_TKEEP, s1_TLAST} = b1;
        s0_TVALID = src_en0 && (q0.size() > 0);
        s1_TVALID = src_en1 && (q1.size() > 0);
    endtask

    task automatic advance(input logic h0, input logic h1);
        if (h0 && q0.size() > 0) q0.delete(0);
        if (h1 && q1.size() > 0) q1.delete(0);
        drive_srcs();
    endtask

    // Queue a packet on a source and its expected output beats.
    task automatic queue_pkt(input int src, input int n, input logic [DW-1:0] base, input logic en);
        beat_t b;
        exp_t  e;
        for (int i = 0; i < n; i++) begin
            b.d = base + DW'(i);
            b.k = (i == n - 1) ? 4'h3 : 4'hF;
            b.l = (i == n - 1);
            if (src == 0) q0.push_back(b); else q1.push_back(b);
            e.d = b.d; e.k = b.k; e.l = b.l; e.en = en;
            e.g = (src == 0) ? 2'b01 : 2'b10;
            exp_q.push_back(e);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        src_en0 = 1'b0; src_en1 = 1'b0;
        q0.delete(); q1.delete(); exp_q.delete();
        out_TREADY = 1'b1;
        drive_srcs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        swap_cfg = 2'b11;
        out_TREADY = 1'b1;
        q0.delete(); q1.delete(); exp_q.delete();
        src_en0 = 1'b1; src_en1 = 1'b1;
        q0.push_back({32'hDEAD0000, 4'hF, 1'b1});
        q1.push_back({32'hDEAD0001, 4'hF, 1'b1});
        drive_srcs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++;
        if ({out_TVALID, s0_TREADY, s1_TREADY, grant, enable_swap} !== 6'b0) begin
            fails++;
            $display("FAIL reset_outputs: got vld=%b rdy0=%b rdy1=%b gnt=%b en=%b, want all 0",
                     out_TVALID, s0_TREADY, s1_TREADY, grant, enable_swap);
        end
        tests++;
        if (pkt_count0 !== '0 || pkt_count1 !== '0) begin
            fails++;
            $display("FAIL reset_counters: got %0d/%0d, want 0/0", pkt_count0, pkt_count1);
        end
        do_reset();
        @(negedge clk);
        tests++;
        if (grant !== 2'b00 || out_TVALID !== 1'b0) begin
            fails++;
            $display("FAIL reset_exit_idle: got gnt=%b vld=%b, want 00/0", grant, out_TVALID);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single_source();
        logic h0, h1;
        exp_t e;
        swap_cfg = 2'b01;
        queue_pkt(0, 3, 32'h11223344, 1'b1);
        src_en0 = 1'b1;
        drive_srcs();
        @(negedge clk);
        tests++;
        if (grant !== 2'b00 || out_TVALID !== 1'b0 || s0_TREADY !== 1'b0) begin
            fails++;
            $display("FAIL single_first_cycle_idle: got gnt=%b vld=%b rdy0=%b, want 00/0/0",
                     grant, out_TVALID, s0_TREADY);
        end
        @(posedge clk); #1;
        for (int c = 0; c < 50 && exp_q.size() > 0; c++) begin
            @(negedge clk);
            h0 = s0_TVALID && s0_TREADY;
            h1 = s1_TVALID && s1_TREADY;
            if (out_TVALID && out_TREADY) begin
                tests++;
                e = exp_q.pop_front();
                if ({out_TDATA, out_TKEEP, out_TLAST, enable_swap, grant} !== e) begin
                    fails++;
                    $display("FAIL single_beat: got d=%h k=%h l=%b en=%b g=%b, want d=%h k=%h l=%b en=%b g=%b",
                             out_TDATA, out_TKEEP, out_TLAST, enable_swap, grant, e.d, e.k, e.l, e.en, e.g);
                end
            end
            @(posedge clk); #1;
            advance(h0, h1);
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL single_timeout: %0d beats outstanding, want 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
        tests++;
        if (grant !== 2'b00 || pkt_count0 !== 8'd1 || enable_swap !== 1'b1) begin
            fails++;
            $display("FAIL single_end: got gnt=%b cnt0=%0d en=%b, want 00/1/1",
                     grant, pkt_count0, enable_swap);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_alternation();
        logic h0, h1, prev_end;
        int   diff;
        exp_t e;
        do_reset();
        swap_cfg = 2'b10;
        for (int p = 0; p < 3; p++) begin
            queue_pkt(0, 2, 32'hA000_0000 + DW'(p * 16), 1'b0);
            queue_pkt(1, 2, 32'hB000_0000 + DW'(p * 16), 1'b1);
        end
        src_en0 = 1'b1; src_en1 = 1'b1;
        drive_srcs();
        prev_end = 1'b0;
        for (int c = 0; c < 100 && exp_q.size() > 0; c++) begin
            @(negedge clk);
            h0 = s0_TVALID && s0_TREADY;
            h1 = s1_TVALID && s1_TREADY;
            if (prev_end) begin
                tests++;
                if (grant !== 2'b00 || out_TVALID !== 1'b0) begin
                    fails++;
                    $display("FAIL alt_bubble: got gnt=%b vld=%b, want 00/0", grant, out_TVALID);
                end
            end
            diff = int'(pkt_count0) - int'(pkt_count1);
            tests++;
            if (diff > 1 || diff < -1) begin
                fails++;
                $display("FAIL alt_count_balance: got %0d vs %0d, want within 1", pkt_count0, pkt_count1);
            end
            prev_end = out_TVALID && out_TREADY && out_TLAST;
            if (out_TVALID && out_TREADY) begin
                tests++;
                e = exp_q.pop_front();
                if ({out_TDATA, out_TKEEP, out_TLAST, enable_swap, grant} !== e) begin
                    fails++;
                    $display("FAIL alt_beat: got d=%h l=%b en=%b g=%b, want d=%h l=%b en=%b g=%b",
                             out_TDATA, out_TLAST, enable_swap, grant, e.d, e.l, e.en, e.g);
                end
            end
            @(posedge clk); #1;
            advance(h0, h1);
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL alt_timeout: %0d beats outstanding, want 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
        tests++;
        if (pkt_count0 !== 8'd3 || pkt_count1 !== 8'd3) begin
            fails++;
            $display("FAIL alt_counts: got %0d/%0d, want 3/3", pkt_count0, pkt_count1);
        end
        @(posedge clk); #1;
        src_en0 = 1'b0; src_en1 = 1'b0;
        drive_srcs();
    endtask

    task automatic test_cfg_hold();
        logic h0, h1;
        int   beats;
        exp_t e;
        swap_cfg = 2'b10;
        queue_pkt(1, 4, 32'hC0C0_0000, 1'b1);
        queue_pkt(1, 1, 32'hC1C1_0000, 1'b0);
        src_en1 = 1'b1;
        drive_srcs();
        beats = 0;
        for (int c = 0; c < 50 && exp_q.size() > 0; c++) begin
            @(negedge clk);
            h0 = s0_TVALID && s0_TREADY;
            h1 = s1_TVALID && s1_TREADY;
            if (out_TVALID && out_TREADY) begin
                tests++;
                beats++;
                e = exp_q.pop_front();
                if ({out_TDATA, out_TKEEP, out_TLAST, enable_swap, grant} !== e) begin
                    fails++;
                    $display("FAIL cfg_hold_beat: got d=%h en=%b g=%b, want d=%h en=%b g=%b",
                             out_TDATA, enable_swap, grant, e.d, e.en, e.g);
                end
            end
            @(posedge clk); #1;
            if (beats == 1) swap_cfg = 2'b01;
            advance(h0, h1);
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL cfg_hold_timeout: %0d beats outstanding, want 0", exp_q.size());
            exp_q.delete();
        end
        src_en1 = 1'b0;
        drive_srcs();
    endtask

    task automatic test_backpressure();
        logic h0, h1;
        exp_t e;
        swap_cfg = 2'b00;
        queue_pkt(0, 4, 32'h5050_0000, 1'b0);
        queue_pkt(1, 2, 32'h6060_0000, 1'b0);
        src_en0 = 1'b1; src_en1 = 1'b1;
        drive_srcs();
        for (int c = 0; c < 60 && exp_q.size() > 0; c++) begin
            @(negedge clk);
            h0 = s0_TVALID && s0_TREADY;
            h1 = s1_TVALID && s1_TREADY;
            if (grant == 2'b01) begin
                tests++;
                if (s1_TREADY !== 1'b0) begin
                    fails++;
                    $display("FAIL bp_other_ready: got s1_TREADY=%b, want 0", s1_TREADY);
                end
            end
            if (!out_TREADY) begin
                tests++;
                if (out_TVALID !== 1'b1 || out_TDATA !== exp_q[0].d || s0_TREADY !== 1'b0) begin
                    fails++;
                    $display("FAIL bp_stall_hold: got vld=%b d=%h rdy0=%b, want 1/%h/0",
                             out_TVALID, out_TDATA, s0_TREADY, exp_q[0].d);
                end
            end
            if (out_TVALID && out_TREADY) begin
                tests++;
                e = exp_q.pop_front();
                if ({out_TDATA, out_TKEEP, out_TLAST, enable_swap, grant} !== e) begin
                    fails++;
                    $display("FAIL bp_beat: got d=%h l=%b g=%b, want d=%h l=%b g=%b",
                             out_TDATA, out_TLAST, grant, e.d, e.l, e.g);
                end
            end
            @(posedge clk); #1;
            out_TREADY = !(c >= 1 && c < 6);
            advance(h0, h1);
        end
        out_TREADY = 1'b1;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL bp_timeout: %0d beats outstanding, want 0", exp_q.size());
            exp_q.delete();
        end
        src_en0 = 1'b0; src_en1 = 1'b0;
        drive_srcs();
    endtask

    task automatic test_reset_mid_packet();
        logic h0, h1;
        exp_t e;
        swap_cfg = 2'b01;
        queue_pkt(0, 4, 32'h7070_0000, 1'b1);
        src_en0 = 1'b1;
        drive_srcs();
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        tests++;
        e = exp_q.pop_front();
        if (out_TVALID !== 1'b1 || out_TDATA !== e.d || grant !== 2'b01) begin
            fails++;
            $display("FAIL rstmid_beat1: got vld=%b d=%h g=%b, want 1/%h/01", out_TVALID, out_TDATA, grant, e.d);
        end
        @(posedge clk); #1;
        advance(1'b1, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        tests++;
        if ({out_TVALID, s0_TREADY, s1_TREADY, grant, enable_swap} !== 6'b0 ||
            pkt_count0 !== '0 || pkt_count1 !== '0) begin
            fails++;
            $display("FAIL rstmid_clear: got vld=%b rdy0=%b rdy1=%b g=%b en=%b cnt=%0d/%0d, want all 0",
                     out_TVALID, s0_TREADY, s1_TREADY, grant, enable_swap, pkt_count0, pkt_count1);
        end
        do_reset();
        swap_cfg = 2'b00;
        queue_pkt(0, 1, 32'h8000_0000, 1'b0);
        queue_pkt(1, 1, 32'h8100_0000, 1'b0);
        src_en0 = 1'b1; src_en1 = 1'b1;
        drive_srcs();
        for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
            @(negedge clk);
            h0 = s0_TVALID && s0_TREADY;
            h1 = s1_TVALID && s1_TREADY;
            if (out_TVALID && out_TREADY) begin
                tests++;
                e = exp_q.pop_front();
                if ({out_TDATA, out_TKEEP, out_TLAST, enable_swap, grant} !== e) begin
                    fails++;
                    $display("FAIL rstmid_regrant: got d=%h g=%b, want d=%h g=%b", out_TDATA, grant, e.d, e.g);
                end
            end
            @(posedge clk); #1;
            advance(h0, h1);
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL rstmid_timeout: %0d beats outstanding, want 0", exp_q.size());
            exp_q.delete();
        end
        src_en0 = 1'b0; src_en1 = 1'b0;
        drive_srcs();
    endtask

    task automatic test_counter_wrap();
        logic h0, h1;
        exp_t e;
        int   nfail;
        do_reset();
        swap_cfg = 2'b00;
        for (int p = 0; p < 255; p++) queue_pkt(0, 1, DW'(p), 1'b0);
        src_en0 = 1'b1;
        drive_srcs();
        nfail = 0;
        for (int c = 0; c < 1200 && exp_q.size() > 0; c++) begin
            @(negedge clk);
            h0 = s0_TVALID && s0_TREADY;
            h1 = s1_TVALID && s1_TREADY;
            if (out_TVALID && out_TREADY) begin
                e = exp_q.pop_front();
                if ({out_TDATA, out_TKEEP, out_TLAST, enable_swap, grant} !== e) nfail++;
            end
            @(posedge clk); #1;
            advance(h0, h1);
        end
        tests++;
        if (nfail != 0 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL wrap_stream: got %0d bad beats, %0d outstanding, want 0/0", nfail, exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
        tests++;
        if (pkt_count0 !== 8'hFF) begin
            fails++;
            $display("FAIL wrap_preload: got %0d, want 255", pkt_count0);
        end
        @(posedge clk); #1;
        queue_pkt(0, 1, 32'hFFFF_0000, 1'b0);
        drive_srcs();
        for (int c = 0; c < 10 && exp_q.size() > 0; c++) begin
            @(negedge clk);
            h0 = s0_TVALID && s0_TREADY;
            h1 = s1_TVALID && s1_TREADY;
            if (out_TVALID && out_TREADY) void'(exp_q.pop_front());
            @(posedge clk); #1;
            advance(h0, h1);
        end
        @(negedge clk);
        tests++;
        if (pkt_count0 !== 8'h00 || pkt_count1 !== 8'h00 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL wrap_to_zero: got cnt0=%0d cnt1=%0d outstanding=%0d, want 0/0/0",
                     pkt_count0, pkt_count1, exp_q.size());
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_single_source();
        test_alternation();
        test_cfg_hold();
        test_backpressure();
        test_reset_mid_packet();
        test_counter_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
